// File: rtl/branch_resolve_unit_if.sv
// Fetch/execute-facing bundle of the branch resolve unit.
// Optional statistics ports are present only when BRU_STATS_EN is defined.
interface branch_resolve_unit_if #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned IDX_W = 4,
    parameter int unsigned PC_W  = 32
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic             push;
    logic             push_pred;
    logic [IDX_W-1:0] push_idx;
    logic [PC_W-1:0]  push_fall;
    logic [PC_W-1:0]  push_tgt;
    logic             full;
    logic             empty;
    logic [CNT_W-1:0] count;
    logic             resolve;
    logic             resolve_taken;
    logic             upd_en;
    logic [IDX_W-1:0] upd_idx;
    logic             upd_taken;
    logic             flush;
    logic [PC_W-1:0]  redirect_pc;
    logic             proto_err;
`ifdef BRU_STATS_EN
    logic [15:0]      br_count;
    logic [15:0]      mis_count;
`endif

    // Fetch/execute side
    modport master (
        output push, push_pred, push_idx, push_fall, push_tgt, resolve, resolve_taken,
        input  full, empty, count, upd_en, upd_idx, upd_taken, flush, redirect_pc,
`ifdef BRU_STATS_EN
        input  br_count, mis_count,
`endif
        input  proto_err
    );

    // Resolve unit side
    modport slave (
        input  push, push_pred, push_idx, push_fall, push_tgt, resolve, resolve_taken,
        output full, empty, count, upd_en, upd_idx, upd_taken, flush, redirect_pc,
`ifdef BRU_STATS_EN
        output br_count, mis_count,
`endif
        output proto_err
    );
endinterface

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: in-order FIFO of predicted branches, predictor training
// strobe and mispredict flush/redirect.
// Optional macro BRU_STATS_EN adds saturating resolve/mispredict counters.
module branch_resolve_unit #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned IDX_W = 4,
    parameter int unsigned PC_W  = 32
) (
    input  logic                  CLK,
    input  logic                  nRST,
    branch_resolve_unit_if.slave  bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    // Record storage; contents are don't-care after reset
    logic             pred_mem [DEPTH];
    logic [IDX_W-1:0] idx_mem  [DEPTH];
    logic [PC_W-1:0]  fall_mem [DEPTH];
    logic [PC_W-1:0]  tgt_mem  [DEPTH];

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             upd_en_q, upd_en_d;
    logic [IDX_W-1:0] upd_idx_q, upd_idx_d;
    logic             upd_taken_q, upd_taken_d;
    logic             flush_q, flush_d;
    logic [PC_W-1:0]  redirect_q, redirect_d;
    logic             err_q, err_d;

    logic is_full, is_empty;
    logic resolve_ok, mispredict, push_ok, push_err, resolve_err;

    assign is_full  = (count_q == CNT_W'(DEPTH));
    assign is_empty = (count_q == '0);

    // Decode this cycle's push/resolve outcome
    always_comb begin
        resolve_ok  = bus.resolve && !is_empty;
        resolve_err = bus.resolve && is_empty;
        mispredict  = resolve_ok && (bus.resolve_taken != pred_mem[head_q]);
        // A push alongside a mispredict is wrong-path: dropped silently
        push_ok     = bus.push && !mispredict && (!is_full || resolve_ok);
        push_err    = bus.push && is_full && !resolve_ok;
    end

    // Next-state for pointers, count and registered outputs
    always_comb begin
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        err_d       = err_q | push_err | resolve_err;
        upd_en_d    = resolve_ok;
        upd_idx_d   = resolve_ok ? idx_mem[head_q] : upd_idx_q;
        upd_taken_d = resolve_ok ? bus.resolve_taken : upd_taken_q;
        flush_d     = mispredict;
        redirect_d  = redirect_q;
        if (mispredict) begin
            redirect_d = bus.resolve_taken ? tgt_mem[head_q] : fall_mem[head_q];
        end
        if (resolve_ok) begin
            head_d = head_q + PTR_W'(1);
        end
        if (mispredict) begin
            // Squash every younger record
            tail_d  = head_q + PTR_W'(1);
            count_d = '0;
        end else begin
            if (push_ok) begin
                tail_d = tail_q + PTR_W'(1);
            end
            case ({push_ok, resolve_ok})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state with synchronous active-low reset
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            upd_en_q    <= 1'b0;
            upd_idx_q   <= '0;
            upd_taken_q <= 1'b0;
            flush_q     <= 1'b0;
            redirect_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            upd_en_q    <= upd_en_d;
            upd_idx_q   <= upd_idx_d;
            upd_taken_q <= upd_taken_d;
            flush_q     <= flush_d;
            redirect_q  <= redirect_d;
            err_q       <= err_d;
        end
    end

    // Record write at tail; no reset needed on the data path
    always_ff @(posedge CLK) begin
        if (nRST && push_ok) begin
            pred_mem[tail_q] <= bus.push_pred;
            idx_mem[tail_q]  <= bus.push_idx;
            fall_mem[tail_q] <= bus.push_fall;
            tgt_mem[tail_q]  <= bus.push_tgt;
        end
    end

`ifdef BRU_STATS_EN
    logic [15:0] br_q, br_d;
    logic [15:0] mis_q, mis_d;

    // Saturating resolve and mispredict counters
    always_comb begin
        br_d  = br_q;
        mis_d = mis_q;
        if (resolve_ok && (br_q != 16'hFFFF)) begin
            br_d = br_q + 16'd1;
        end
        if (mispredict && (mis_q != 16'hFFFF)) begin
            mis_d = mis_q + 16'd1;
        end
    end

    // Counter state
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            br_q  <= '0;
            mis_q <= '0;
        end else begin
            br_q  <= br_d;
            mis_q <= mis_d;
        end
    end

    assign bus.br_count  = br_q;
    assign bus.mis_count = mis_q;
`endif

    assign bus.full        = is_full;
    assign bus.empty       = is_empty;
    assign bus.count       = count_q;
    assign bus.upd_en      = upd_en_q;
    assign bus.upd_idx     = upd_idx_q;
    assign bus.upd_taken   = upd_taken_q;
    assign bus.flush       = flush_q;
    assign bus.redirect_pc = redirect_q;
    assign bus.proto_err   = err_q;
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Table-driven bench for branch_resolve_unit (DEPTH=4, IDX_W=4, PC_W=32).
module tb_branch_resolve_unit;
    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    branch_resolve_unit_if #(.DEPTH(4), .IDX_W(4), .PC_W(32)) bus ();

    branch_resolve_unit #(.DEPTH(4), .IDX_W(4), .PC_W(32)) dut (
        .CLK  (clk),
        .nRST (rst_n),
        .bus  (bus)
    );

    typedef struct packed {
        logic        rst_n;
        logic        push;
        logic        pred;
        logic [3:0]  idx;
        logic [31:0] fall;
        logic [31:0] tgt;
        logic        resolve;
        logic        taken;
    } in_t;

    typedef struct packed {
        logic        full;
        logic        empty;
        logic [2:0]  count;
        logic        upd_en;
        logic [3:0]  upd_idx;
        logic        upd_taken;
        logic        flush;
        logic [31:0] rpc;
        logic        err;
    } exp_t;

    typedef struct packed {
        in_t  i;
        exp_t e;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic in_t idle();
        in_t t = '0;
        t.rst_n = 1'b1;
        return t;
    endfunction

    function automatic in_t rst();
        in_t t = '0;
        return t;
    endfunction

    function automatic in_t ps(input logic pred, input logic [3:0] idx,
                               input logic [31:0] fall, input logic [31:0] tgt);
        in_t t = idle();
        t.push = 1'b1;
        t.pred = pred;
        t.idx  = idx;
        t.fall = fall;
        t.tgt  = tgt;
        return t;
    endfunction

    function automatic in_t rs(input logic taken);
        in_t t = idle();
        t.resolve = 1'b1;
        t.taken   = taken;
        return t;
    endfunction

    function automatic in_t rsps(input logic taken, input logic pred, input logic [3:0] idx,
                                 input logic [31:0] fall, input logic [31:0] tgt);
        in_t t = ps(pred, idx, fall, tgt);
        t.resolve = 1'b1;
        t.taken   = taken;
        return t;
    endfunction

    function automatic exp_t ex(input int cnt, input logic ue, input logic [3:0] ui,
                                input logic ut, input logic fl, input logic [31:0] rpc,
                                input logic err);
        exp_t e;
        e.full      = (cnt == 4);
        e.empty     = (cnt == 0);
        e.count     = 3'(cnt);
        e.upd_en    = ue;
        e.upd_idx   = ui;
        e.upd_taken = ut;
        e.flush     = fl;
        e.rpc       = rpc;
        e.err       = err;
        return e;
    endfunction

    task automatic add(input in_t i, input exp_t e);
        vec_t v;
        v.i = i;
        v.e = e;
        vecs.push_back(v);
    endtask

    task automatic drive(input in_t v);
        rst_n             = v.rst_n;
        bus.push          = v.push;
        bus.push_pred     = v.pred;
        bus.push_idx      = v.idx;
        bus.push_fall     = v.fall;
        bus.push_tgt      = v.tgt;
        bus.resolve       = v.resolve;
        bus.resolve_taken = v.taken;
    endtask

    // Drive on the falling edge, sample 1 time unit after the rising edge
    task automatic step(input in_t v);
        @(negedge clk);
        drive(v);
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t actual();
        exp_t a;
        a.full      = bus.full;
        a.empty     = bus.empty;
        a.count     = bus.count;
        a.upd_en    = bus.upd_en;
        a.upd_idx   = bus.upd_idx;
        a.upd_taken = bus.upd_taken;
        a.flush     = bus.flush;
        a.rpc       = bus.redirect_pc;
        a.err       = bus.proto_err;
        return a;
    endfunction

    task automatic check_int(input string name, input int got, input int want);
        n_vec++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: actual %0d (0x%0h) required %0d (0x%0h)",
                     name, got, got, want, want);
        end
    endtask

    initial begin
        drive(rst());

        // Correct taken prediction
        add(rst(),                                ex(0, 0, 0, 0, 0, 32'h0,   0));
        add(ps(1, 3, 32'h104, 32'h200),           ex(1, 0, 0, 0, 0, 32'h0,   0));
        add(rs(1),                                ex(0, 1, 3, 1, 0, 32'h0,   0));
        add(idle(),                               ex(0, 0, 3, 1, 0, 32'h0,   0));
        // Mispredict with squash; same-cycle push is wrong-path
        add(ps(0, 1, 32'h10, 32'h80),             ex(1, 0, 3, 1, 0, 32'h0,   0));
        add(ps(0, 2, 32'h20, 32'h90),             ex(2, 0, 3, 1, 0, 32'h0,   0));
        add(ps(0, 3, 32'h30, 32'hA0),             ex(3, 0, 3, 1, 0, 32'h0,   0));
        add(rsps(1, 1, 5, 32'h40, 32'h50),        ex(0, 1, 1, 1, 1, 32'h80,  0));
        add(idle(),                               ex(0, 0, 1, 1, 0, 32'h80,  0));
        // Post-squash slot reuse; not-taken mispredict redirects to fall-through
        add(ps(1, 7, 32'h300, 32'h400),           ex(1, 0, 1, 1, 0, 32'h80,  0));
        add(rs(0),                                ex(0, 1, 7, 0, 1, 32'h300, 0));
        add(idle(),                               ex(0, 0, 7, 0, 0, 32'h300, 0));
        // Resolve while empty: ignored, sticky error
        add(rs(1),                                ex(0, 0, 7, 0, 0, 32'h300, 1));
        add(idle(),                               ex(0, 0, 7, 0, 0, 32'h300, 1));
        add(ps(0, 2, 32'h10, 32'h20),             ex(1, 0, 7, 0, 0, 32'h300, 1));
        add(rs(0),                                ex(0, 1, 2, 0, 0, 32'h300, 1));
        add(rst(),                                ex(0, 0, 0, 0, 0, 32'h0,   0));
        // Fill and overflow
        for (int k = 0; k < 4; k++) begin
            add(ps(1, 4'(8 + k), 32'h1000 + 32'(k), 32'h2000), ex(k + 1, 0, 0, 0, 0, 32'h0, 0));
        end
        add(ps(1, 12, 32'h1004, 32'h2000),        ex(4, 0, 0, 0, 0, 32'h0,   1));
        add(rst(),                                ex(0, 0, 0, 0, 0, 32'h0,   0));
        // Wrap: fill, then back-to-back resolve+push, then drain
        for (int k = 0; k < 4; k++) begin
            add(ps(1, 4'(1 + k), 32'h100, 32'h200), ex(k + 1, 0, 0, 0, 0, 32'h0, 0));
        end
        for (int k = 0; k < 6; k++) begin
            add(rsps(1, 1, 4'(5 + k), 32'h100, 32'h200), ex(4, 1, 4'(1 + k), 1, 0, 32'h0, 0));
        end
        for (int k = 0; k < 4; k++) begin
            add(rs(1), ex(3 - k, 1, 4'(7 + k), 1, 0, 32'h0, 0));
        end
        add(idle(),                               ex(0, 0, 10, 1, 0, 32'h0,  0));
        // Reset mid-operation with a mispredicting resolve
        add(ps(1, 1, 32'h10, 32'h20),             ex(1, 0, 10, 1, 0, 32'h0,  0));
        add(ps(1, 2, 32'h30, 32'h40),             ex(2, 0, 10, 1, 0, 32'h0,  0));
        begin
            in_t t = rs(0);
            t.rst_n = 1'b0;
            add(t,                                ex(0, 0, 0, 0, 0, 32'h0,   0));
        end
        add(idle(),                               ex(0, 0, 0, 0, 0, 32'h0,   0));

        foreach (vecs[n]) begin
            exp_t a;
            step(vecs[n].i);
            a = actual();
            n_vec++;
            if (a !== vecs[n].e) begin
                n_bad++;
                $display("FAIL vec%0d: actual cnt=%0d f/e=%b%b ue=%b ui=%0d ut=%b fl=%b rpc=%h err=%b required cnt=%0d f/e=%b%b ue=%b ui=%0d ut=%b fl=%b rpc=%h err=%b",
                         n, a.count, a.full, a.empty, a.upd_en, a.upd_idx, a.upd_taken,
                         a.flush, a.rpc, a.err, vecs[n].e.count, vecs[n].e.full,
                         vecs[n].e.empty, vecs[n].e.upd_en, vecs[n].e.upd_idx,
                         vecs[n].e.upd_taken, vecs[n].e.flush, vecs[n].e.rpc, vecs[n].e.err);
            end
        end

        // Flush pulse width over a bounded window after one mispredict
        begin
            int nflush = 0;
            logic [31:0] rpc = '0;
            step(rst());
            step(ps(0, 6, 32'h50, 32'h60));
            step(rs(1));
            rpc = bus.redirect_pc;
            for (int k = 0; k < 5; k++) begin
                if (bus.flush) nflush++;
                step(idle());
            end
            check_int("flush_pulse_count", nflush, 1);
            check_int("flush_redirect_tgt", int'(rpc), 32'h60);
        end

`ifdef BRU_STATS_EN
        // Five resolves, first two mispredicted
        step(rst());
        for (int k = 0; k < 5; k++) begin
            step(ps((k < 2) ? 1'b0 : 1'b1, 4'(k), 32'h10, 32'h20));
            step(rs(1));
        end
        check_int("br_count", int'(bus.br_count), 5);
        check_int("mis_count", int'(bus.mis_count), 2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Consumer and trainer side of the 2-bit branch predictor.
- Fetch pushes a record for every predicted branch: prediction bit, predictor index, fall-through PC, target PC. The record is held in an in-order FIFO.
- When execute resolves the oldest branch, this block does three things:
  - compares the actual outcome against the stored prediction;
  - drives the predictor training strobe (en / ABtaken equivalent);
  - on a mispredict, raises a one-cycle flush with the corrected PC.

Parameters:
DEPTH, 4, number of in-flight branch records (power of 2, >=2)
IDX_W, 4, predictor table index width
PC_W, 32, program counter width

Ports:
CLK  in  1  clock, all state updates on rising edge
nRST  in  1  synchronous active-low reset
push  in  1  fetch records a predicted branch this cycle
push_pred  in  1  prediction given to fetch (1 = taken)
push_idx  in  IDX_W  predictor index used for this branch
push_fall  in  PC_W  fall-through PC (branch PC + 4)
push_tgt  in  PC_W  taken target PC
full  out  1  count == DEPTH
empty  out  1  count == 0
count  out  $clog2(DEPTH)+1  valid record count
resolve  in  1  execute resolves the oldest branch this cycle
resolve_taken  in  1  actual outcome of the resolved branch
upd_en  out  1  one-cycle training strobe to predictor
upd_idx  out  IDX_W  index to train
upd_taken  out  1  actual outcome to train with
flush  out  1  one-cycle mispredict flush
redirect_pc  out  PC_W  corrected PC, valid while flush = 1
proto_err  out  1  sticky: resolve while empty or push while full

Behaviour:
- Reset (nRST = 0 at a rising edge):
  - head, tail and count return to 0.
  - upd_en, upd_idx, upd_taken, flush, redirect_pc and proto_err all return to 0.
  - Stored record contents are don't-care.
  - Reset mid-operation discards all in-flight records with no flush or update emitted.
- Storage:
  - Circular buffer, DEPTH entries; head and tail wrap modulo DEPTH.
  - full and empty are combinational from count.
- Push:
  - Writes at tail and increments tail and count.
  - Push while full and not resolving is dropped and sets proto_err.
  - Push while full with a resolve in the same cycle is accepted, because the pop frees a slot.
- Resolve with a non-empty FIFO:
  - Pops the head record.
  - On the next cycle: upd_en = 1, upd_idx = head.idx, upd_taken = resolve_taken (registered, 1-cycle latency).
  - If resolve_taken != head.pred: on the next cycle flush = 1, and redirect_pc = head.tgt if resolve_taken, else head.fall.
  - Correct prediction: flush = 0.
- Resolve while empty: ignored; no update and no flush; sets proto_err.
- Mispredict squash:
  - On the resolving edge, all younger records are discarded: count becomes 0 and tail = head + 1.
  - A push in the same cycle as a mispredicting resolve is wrong-path and is dropped. proto_err is not set.
- Push and resolve together with a correct prediction: count is unchanged, head and tail both advance.
- Pulse width: upd_en and flush each last exactly one cycle per resolve. Back-to-back resolves produce back-to-back pulses.
- Idle outputs: redirect_pc holds its last value when flush = 0.
- Clearing proto_err: only reset clears it.

Optional Feature:
- Macro: BRU_STATS_EN.
- Defined:
  - Adds outputs br_count[15:0] and mis_count[15:0].
  - br_count increments on every accepted resolve.
  - mis_count increments on every mispredict.
  - Both counters saturate at 16'hFFFF and reset to 0.
- Undefined: the counters and both ports are absent; all other behaviour is identical.

Test Plan:
- Correct taken prediction:
  - Stimulus: reset, then push pred=1 idx=3 fall=0x104 tgt=0x200; next cycle resolve taken=1.
  - Required: the following cycle upd_en=1, upd_idx=3, upd_taken=1, flush=0; count returns to 0.
- Mispredict with squash:
  - Stimulus: push 3 records (pred=0 idx=1/2/3, fall=0x10/0x20/0x30, tgt=0x80/0x90/0xA0); resolve taken=1.
  - Required: next cycle flush=1, redirect_pc=0x80, upd_idx=1, upd_taken=1; count=0; a push in the same cycle is dropped with proto_err=0.
- Fill, overflow and wrap:
  - Stimulus: push 4 records, then a 5th push.
  - Required: full=1 and proto_err=1, count stays 4.
  - Follow-on: after reset, push 4, resolve-and-push 6 times with correct predictions. Required: pointers wrap and each upd_idx matches push order.
- Resolve while empty:
  - Stimulus: resolve=1 with count=0.
  - Required: upd_en=0, flush=0, proto_err=1 and sticky until reset.
- Reset mid-operation:
  - Stimulus: push 2 records, assert resolve with a mispredict in the same cycle that nRST=0.
  - Required: next cycle flush=0, upd_en=0, count=0, empty=1.
- Statistics (BRU_STATS_EN):
  - Stimulus: 5 resolves, 2 of them mispredicted.
  - Required: br_count=5, mis_count=2.
